lpif_txfifo_asym2_gearbox: RTL and testbench

Transmit-side buffer and 2:1 gearbox that sits directly downstream of the LPIF-to-logic-link data mapper. Accepts 154-bit packed downstream words (two 77-bit half-words: bits [76:0] = half 0, [153:77] = half 1) into a small synchronous FIFO. Emits them to the link as 77-bit half-words, half 0 first. In Gen1 mode only half 0 of each word is transmitted.

---
 rtl/lpif_txfifo_pkg.sv | 12 +
 rtl/lpif_sync_fifo.sv | 63 ++++++
 rtl/lpif_txfifo_asym2_gearbox.sv | 110 +++++++++++
 tb/tb_lpif_txfifo_asym2_gearbox.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpif_txfifo_pkg.sv
// Shared widths and gearbox state encoding for the LPIF transmit FIFO and 2:1 gearbox.
package lpif_txfifo_pkg;

    localparam int LPIF_WORD_W = 154;
    localparam int LPIF_HALF_W = 77;

    typedef enum logic {
        GBX_LO = 1'b0,
        GBX_HI = 1'b1
    } gbx_state_e;

endpackage

// File: rtl/lpif_sync_fifo.sv
// Small single-clock FIFO with first-word-fall-through head and an occupancy count.
// Full/empty come from the count, so pointers are free to wrap without an extra bit.
// Storage is deliberately left unreset; only pointers and count are cleared.
module lpif_sync_fifo
    import lpif_txfifo_pkg::*;
#(
    parameter  int WIDTH = LPIF_WORD_W,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Write the incoming word into the slot at the write pointer.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lpif_txfifo_asym2_gearbox.sv
// Transmit buffer plus 2:1 gearbox: 154-bit words in, 77-bit half-words out, half 0 first.
// In Gen1 only half 0 of each word goes out. The mode is latched while the gearbox sits
// in LO and frozen in HI so a word that has started in Gen2 always finishes its half 1.
module lpif_txfifo_asym2_gearbox
    import lpif_txfifo_pkg::*;
#(
    parameter  int FIFO_DEPTH = 4,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                   clk_wr,
    input  logic                   rst_wr,
    input  logic                   m_gen2_mode,
    input  logic [LPIF_WORD_W-1:0] txfifo_downstream_data,
    input  logic                   txfifo_downstream_valid,
    output logic                   txfifo_downstream_ready,
    output logic [LPIF_HALF_W-1:0] tx_half_data,
    output logic                   tx_half_valid,
    input  logic                   tx_half_ready,
    output logic                   tx_half_sel,
    output logic [CNT_W-1:0]       fifo_count,
    output logic                   fifo_full,
    output logic                   fifo_empty
);

    gbx_state_e             state;
    gbx_state_e             state_next;
    logic                   mode_q;
    logic                   push;
    logic                   pop;
    logic                   accept;
    logic [LPIF_WORD_W-1:0] head;

    assign txfifo_downstream_ready = !fifo_full && !rst_wr;
    assign push                    = txfifo_downstream_valid && txfifo_downstream_ready;
    assign tx_half_valid           = !fifo_empty && !rst_wr;
    assign accept                  = tx_half_valid && tx_half_ready;
    assign tx_half_sel             = (state == GBX_HI);

    lpif_sync_fifo #(
        .WIDTH (LPIF_WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_wr),
        .rst   (rst_wr),
        .push  (push),
        .pop   (pop),
        .din   (txfifo_downstream_data),
        .head  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Gearbox state register.
    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            state <= GBX_LO;
        end else begin
            state <= state_next;
        end
    end

    // Track the link mode between words only; hold it while half 1 is pending.
    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            mode_q <= 1'b0;
        end else if (state == GBX_LO) begin
            mode_q <= m_gen2_mode;
        end
    end

    // Next-state and pop decision: a word leaves the FIFO after its last half is accepted.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            GBX_LO: begin
                if (accept) begin
                    if (mode_q) begin
                        state_next = GBX_HI;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            GBX_HI: begin
                if (accept) begin
                    state_next = GBX_LO;
                    pop        = 1'b1;
                end
            end
            default: begin
                state_next = GBX_LO;
            end
        endcase
    end

    // Select the presented half of the head word; drive zero when nothing is valid.
    always_comb begin
        tx_half_data = '0;
        if (tx_half_valid) begin
            if (tx_half_sel) begin
                tx_half_data = head[LPIF_WORD_W-1:LPIF_HALF_W];
            end else begin
                tx_half_data = head[LPIF_HALF_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_lpif_txfifo_asym2_gearbox.sv
// Directed scoreboard bench for the LPIF transmit FIFO / 2:1 gearbox.
module tb_lpif_txfifo_asym2_gearbox;

    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int WORD_W = 154;
    localparam int HALF_W = 77;

    logic              clk_wr = 1'b0;
    logic              rst_wr;
    logic              m_gen2_mode;
    logic [WORD_W-1:0] down_data;
    logic              down_valid;
    logic              down_ready;
    logic [HALF_W-1:0] tx_half_data;
    logic              tx_half_valid;
    logic              tx_half_ready;
    logic              tx_half_sel;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    int nCompared   = 0;
    int nMismatched = 0;
    int emitCount   = 0;

    logic [HALF_W:0] expQ [$];

    lpif_txfifo_asym2_gearbox #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_wr                  (clk_wr),
        .rst_wr                  (rst_wr),
        .m_gen2_mode             (m_gen2_mode),
        .txfifo_downstream_data  (down_data),
        .txfifo_downstream_valid (down_valid),
        .txfifo_downstream_ready (down_ready),
        .tx_half_data            (tx_half_data),
        .tx_half_valid           (tx_half_valid),
        .tx_half_ready           (tx_half_ready),
        .tx_half_sel             (tx_half_sel),
        .fifo_count              (fifo_count),
        .fifo_full               (fifo_full),
        .fifo_empty              (fifo_empty)
    );

    // Free-running block clock.
    always #5 clk_wr = ~clk_wr;

    task automatic checkOutput(input string tag, input logic [79:0] observed, input logic [79:0] expected);
        nCompared++;
        assert (observed === expected)
        else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one word until accepted; optionally record its expected half-words.
    task automatic applyStimulus(input logic [WORD_W-1:0] word, input logic gen2, input logic record);
        int waitCycles = 0;
        down_data  = word;
        down_valid = 1'b1;
        @(negedge clk_wr);
        while (!down_ready && waitCycles < 60) begin
            @(negedge clk_wr);
            waitCycles++;
        end
        if (!down_ready) begin
            checkOutput("push_timeout", {79'd0, down_ready}, 80'd1);
        end else if (record) begin
            expQ.push_back({1'b0, word[HALF_W-1:0]});
            if (gen2) expQ.push_back({1'b1, word[WORD_W-1:HALF_W]});
        end
        @(posedge clk_wr);
        #1;
        down_valid = 1'b0;
    endtask

    // Wait until every expected half has been seen and the output is idle.
    task automatic waitDrain(input string tag);
        int budget = 0;
        @(negedge clk_wr);
        while ((expQ.size() != 0 || tx_half_valid) && budget < 100) begin
            @(negedge clk_wr);
            budget++;
        end
        checkOutput(tag, 80'(expQ.size()), 80'd0);
    endtask

    // Scoreboard: every accepted half-word must match the oldest expected entry.
    always @(negedge clk_wr) begin
        if (tx_half_valid && tx_half_ready) begin
            emitCount++;
            if (expQ.size() == 0) begin
                checkOutput("unexpected_half", 80'(expQ.size()), 80'd1);
            end else begin
                checkOutput("half_word", {2'b0, tx_half_sel, tx_half_data}, {2'b0, expQ.pop_front()});
            end
        end
    end

    initial begin
        logic [WORD_W-1:0] w;
        logic [HALF_W-1:0] heldData;
        int                emitBase;

        rst_wr        = 1'b1;
        m_gen2_mode   = 1'b1;
        down_data     = '0;
        down_valid    = 1'b0;
        tx_half_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk_wr);
        @(negedge clk_wr);
        checkOutput("rst_ready",  {79'd0, down_ready},    80'd0);
        checkOutput("rst_valid",  {79'd0, tx_half_valid}, 80'd0);
        checkOutput("rst_data",   {3'd0, tx_half_data},   80'd0);
        checkOutput("rst_count",  80'(fifo_count),        80'd0);
        @(posedge clk_wr);
        #1;
        rst_wr = 1'b0;
        @(negedge clk_wr);
        checkOutput("post_rst_ready", {79'd0, down_ready},  80'd1);
        checkOutput("post_rst_empty", {79'd0, fifo_empty},  80'd1);
        checkOutput("post_rst_full",  {79'd0, fifo_full},   80'd0);
        checkOutput("post_rst_sel",   {79'd0, tx_half_sel}, 80'd0);

        // Single Gen2 word with exact per-cycle timing
        @(posedge clk_wr);
        #1;
        w = {77'h1_2345, 77'h0_ABCD};
        applyStimulus(w, 1'b1, 1'b1);
        @(negedge clk_wr);
        checkOutput("g2_n1_valid", {79'd0, tx_half_valid}, 80'd1);
        checkOutput("g2_n1_data",  {3'd0, tx_half_data},   80'h0ABCD);
        checkOutput("g2_n1_sel",   {79'd0, tx_half_sel},   80'd0);
        @(negedge clk_wr);
        checkOutput("g2_n2_data",  {3'd0, tx_half_data},   80'h12345);
        checkOutput("g2_n2_sel",   {79'd0, tx_half_sel},   80'd1);
        @(negedge clk_wr);
        checkOutput("g2_n3_valid", {79'd0, tx_half_valid}, 80'd0);

        // Gen1: three words, half 0 only, one per cycle
        @(posedge clk_wr);
        #1;
        m_gen2_mode = 1'b0;
        repeat (2) @(posedge clk_wr);
        #1;
        emitBase = emitCount;
        for (int i = 0; i < 3; i++) begin
            w = {77'($urandom), 45'd0, 32'($urandom)} ^ {WORD_W{1'b0}} | WORD_W'(i + 1);
            applyStimulus(w, 1'b0, 1'b1);
        end
        waitDrain("gen1_drain");
        checkOutput("gen1_emits", 80'(emitCount - emitBase), 80'd3);

        // Fill to depth with the link stalled, then attempt a fifth push
        @(posedge clk_wr);
        #1;
        m_gen2_mode   = 1'b1;
        tx_half_ready = 1'b0;
        repeat (2) @(posedge clk_wr);
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            w = {77'(32'hA000 + i), 77'(32'hB000 + i)};
            applyStimulus(w, 1'b1, 1'b1);
        end
        @(negedge clk_wr);
        checkOutput("full_count", 80'(fifo_count),     80'd4);
        checkOutput("full_flag",  {79'd0, fifo_full},  80'd1);
        checkOutput("full_ready", {79'd0, down_ready}, 80'd0);
        @(posedge clk_wr);
        #1;
        down_data  = {77'h7_7777, 77'h6_6666};
        down_valid = 1'b1;
        @(posedge clk_wr);
        #1;
        down_valid = 1'b0;
        @(negedge clk_wr);
        checkOutput("full_no_push", 80'(fifo_count), 80'd4);
        @(posedge clk_wr);
        #1;
        tx_half_ready = 1'b1;
        waitDrain("full_drain");

        // Six-word burst across the pointer wrap
        @(posedge clk_wr);
        #1;
        for (int i = 0; i < 6; i++) begin
            w = {77'(32'hC100 + i), 77'(32'hD200 + i)};
            applyStimulus(w, 1'b1, 1'b1);
        end
        waitDrain("wrap_drain");

        // Mode change mid-word: half 1 still sent, next word goes out Gen1
        @(posedge clk_wr);
        #1;
        applyStimulus({77'h1_1111, 77'h0_2222}, 1'b1, 1'b1);
        @(posedge clk_wr);
        #1;
        m_gen2_mode = 1'b0;
        @(negedge clk_wr);
        checkOutput("mode_in_hi_sel", {79'd0, tx_half_sel}, 80'd1);
        repeat (3) @(posedge clk_wr);
        #1;
        applyStimulus({77'h1_3333, 77'h0_4444}, 1'b0, 1'b1);
        waitDrain("mode_drain");

        // Stall pattern 1,0,0,1 on tx_half_ready
        @(posedge clk_wr);
        #1;
        m_gen2_mode = 1'b1;
        repeat (2) @(posedge clk_wr);
        #1;
        emitBase = emitCount;
        applyStimulus({77'h1_5A5A, 77'h0_A5A5}, 1'b1, 1'b1);
        @(posedge clk_wr);
        #1;
        tx_half_ready = 1'b0;
        @(negedge clk_wr);
        heldData = tx_half_data;
        checkOutput("stall_sel0",  {79'd0, tx_half_sel}, 80'd1);
        checkOutput("stall_data0", {3'd0, heldData},     80'h15A5A);
        @(posedge clk_wr);
        #1;
        @(negedge clk_wr);
        checkOutput("stall_sel1",  {79'd0, tx_half_sel}, 80'd1);
        checkOutput("stall_data1", {3'd0, tx_half_data}, {3'd0, heldData});
        @(posedge clk_wr);
        #1;
        tx_half_ready = 1'b1;
        waitDrain("stall_drain");
        checkOutput("stall_emits", 80'(emitCount - emitBase), 80'd2);

        // Reset while in HI with two words queued
        @(posedge clk_wr);
        #1;
        tx_half_ready = 1'b0;
        w = {77'h1_EEEE, 77'h0_DDDD};
        applyStimulus(w, 1'b1, 1'b0);
        applyStimulus({77'h1_FFFF, 77'h0_CCCC}, 1'b1, 1'b0);
        expQ.push_back({1'b0, w[HALF_W-1:0]});
        tx_half_ready = 1'b1;
        @(posedge clk_wr);
        #1;
        tx_half_ready = 1'b0;
        @(negedge clk_wr);
        checkOutput("pre_rst_sel",   {79'd0, tx_half_sel}, 80'd1);
        checkOutput("pre_rst_count", 80'(fifo_count),      80'd2);
        @(posedge clk_wr);
        #1;
        rst_wr = 1'b1;
        @(negedge clk_wr);
        checkOutput("mid_rst_ready", {79'd0, down_ready},    80'd0);
        checkOutput("mid_rst_valid", {79'd0, tx_half_valid}, 80'd0);
        @(posedge clk_wr);
        #1;
        rst_wr = 1'b0;
        @(negedge clk_wr);
        checkOutput("after_rst_count", 80'(fifo_count),        80'd0);
        checkOutput("after_rst_empty", {79'd0, fifo_empty},    80'd1);
        checkOutput("after_rst_valid", {79'd0, tx_half_valid}, 80'd0);
        checkOutput("after_rst_sel",   {79'd0, tx_half_sel},   80'd0);
        @(posedge clk_wr);
        #1;
        tx_half_ready = 1'b1;
        repeat (2) @(posedge clk_wr);
        #1;
        applyStimulus({77'h1_0F0F, 77'h0_F0F0}, 1'b1, 1'b1);
        waitDrain("after_rst_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
